// File: rtl/aes_stream_engine.sv
// aes_stream_engine: engine-side datapath for the AES HWPE.
// Packs plaintext stream words into one cipher block, hands it to the cipher
// core over req/ack, then serialises the ciphertext onto the sink stream.
module aes_stream_engine #(
    parameter  int unsigned DATA_WIDTH  = 32,
    parameter  int unsigned BLOCK_WIDTH = 128,
    localparam int unsigned NB_WORDS    = BLOCK_WIDTH / DATA_WIDTH,
    localparam int unsigned CNT_W       = $clog2(NB_WORDS),
    localparam int unsigned STRB_W      = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   start_i,
    input  logic                   pt_valid_i,
    output logic                   pt_ready_o,
    input  logic [DATA_WIDTH-1:0]  pt_data_i,
    input  logic [STRB_W-1:0]      pt_strb_i,
    output logic                   ct_valid_o,
    input  logic                   ct_ready_i,
    output logic [DATA_WIDTH-1:0]  ct_data_o,
    output logic [STRB_W-1:0]      ct_strb_o,
    output logic                   core_req_o,
    output logic [BLOCK_WIDTH-1:0] core_block_o,
    input  logic                   core_ack_i,
    input  logic [BLOCK_WIDTH-1:0] core_result_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   strb_err_o,
    output logic [CNT_W-1:0]       word_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CIPHER,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [BLOCK_WIDTH-1:0] r_block;
    logic [BLOCK_WIDTH-1:0] r_result;
    logic                   r_strb_err;
    logic [DATA_WIDTH-1:0]  w_pt_masked;
    logic                   w_pt_hs;
    logic                   w_ct_hs;
    logic                   w_last;
    logic                   w_start;

    assign w_last  = (r_cnt == CNT_W'(NB_WORDS - 1));
    assign w_pt_hs = pt_valid_i && (r_state == S_LOAD);
    assign w_ct_hs = ct_ready_i && (r_state == S_DRAIN);
    assign w_start = start_i && (r_state == S_IDLE);

    // Zero every plaintext byte whose strobe is low.
    always_comb begin
        w_pt_masked = '0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            if (pt_strb_i[i]) begin
                w_pt_masked[i*8 +: 8] = pt_data_i[i*8 +: 8];
            end
        end
    end

    // State register; clear behaves exactly like reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state handshake outputs.
    always_comb begin
        w_state_next = r_state;
        pt_ready_o   = 1'b0;
        ct_valid_o   = 1'b0;
        core_req_o   = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                pt_ready_o = 1'b1;
                if (w_pt_hs && w_last) w_state_next = S_CIPHER;
            end
            S_CIPHER: begin
                core_req_o = 1'b1;
                if (core_ack_i) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                ct_valid_o = 1'b1;
                if (w_ct_hs && w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                done_o       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Word counter, block/result registers and sticky strobe error.
    // The counter is shared between LOAD and DRAIN; it wraps to 0 at the end of each.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_block    <= '0;
            r_result   <= '0;
            r_strb_err <= 1'b0;
        end else if (clear) begin
            r_cnt      <= '0;
            r_block    <= '0;
            r_result   <= '0;
            r_strb_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt      <= '0;
                r_strb_err <= 1'b0;
            end
            if (w_pt_hs) begin
                r_block[r_cnt*DATA_WIDTH +: DATA_WIDTH] <= w_pt_masked;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                if (pt_strb_i != '1) r_strb_err <= 1'b1;
            end
            if ((r_state == S_CIPHER) && core_ack_i) begin
                r_result <= core_result_i;
            end
            if (w_ct_hs) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign ct_data_o    = r_result[r_cnt*DATA_WIDTH +: DATA_WIDTH];
    assign ct_strb_o    = '1;
    assign core_block_o = r_block;
    assign busy_o       = (r_state != S_IDLE);
    assign strb_err_o   = r_strb_err;
    assign word_cnt_o   = r_cnt;

endmodule

// File: tb/tb_aes_stream_engine.sv
// Scoreboard bench for aes_stream_engine: stimulus pushes expected blocks,
// ciphertext words and status into queues; an independent monitor pops them.
module tb_aes_stream_engine;

    localparam int unsigned DW = 32;
    localparam int unsigned BW = 128;

    logic          clk = 1'b0;
    logic          reset_n, clear, start_i;
    logic          pt_valid_i, pt_ready_o;
    logic [31:0]   pt_data_i;
    logic [3:0]    pt_strb_i;
    logic          ct_valid_o, ct_ready_i;
    logic [31:0]   ct_data_o;
    logic [3:0]    ct_strb_o;
    logic          core_req_o, core_ack_i;
    logic [127:0]  core_block_o, core_result_i;
    logic          busy_o, done_o, strb_err_o;
    logic [1:0]    word_cnt_o;

    always #5 clk = ~clk;

    aes_stream_engine #(.DATA_WIDTH(DW), .BLOCK_WIDTH(BW)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .start_i(start_i),
        .pt_valid_i(pt_valid_i), .pt_ready_o(pt_ready_o), .pt_data_i(pt_data_i), .pt_strb_i(pt_strb_i),
        .ct_valid_o(ct_valid_o), .ct_ready_i(ct_ready_i), .ct_data_o(ct_data_o), .ct_strb_o(ct_strb_o),
        .core_req_o(core_req_o), .core_block_o(core_block_o), .core_ack_i(core_ack_i),
        .core_result_i(core_result_i), .busy_o(busy_o), .done_o(done_o), .strb_err_o(strb_err_o),
        .word_cnt_o(word_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_block_q[$];
    logic [31:0]  exp_word_q[$];
    logic         exp_err_q[$];
    int           exp_reqlen_q[$];
    int           exp_lat_q[$];
    int           exp_done = 0;
    int           done_cnt = 0;

    logic [127:0] key = '1;
    int           ack_delay = 0;
    int           ready_mode = 0;
    bit           spur_ack_en = 1'b0;

    logic [31:0]  tw[4];
    logic [3:0]   ts[4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred/expired, required otherwise", name);
    endtask

    // Cipher core model: acks after ack_delay cycles of req; optional stray acks while loading.
    initial begin
        int req_cycles;
        req_cycles    = 0;
        core_ack_i    = 1'b0;
        core_result_i = '0;
        forever begin
            @(posedge clk); #1;
            core_ack_i = 1'b0;
            if (core_req_o) begin
                if (req_cycles == ack_delay) begin
                    core_ack_i    = 1'b1;
                    core_result_i = core_block_o ^ key;
                    req_cycles    = 0;
                end else begin
                    req_cycles++;
                end
            end else begin
                req_cycles = 0;
                if (spur_ack_en && pt_ready_o) begin
                    core_ack_i    = 1'b1;
                    core_result_i = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    end

    // Ciphertext sink ready: always / toggling / random.
    initial begin
        ct_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       ct_ready_i = 1'b1;
                1:       ct_ready_i = ~ct_ready_i;
                default: ct_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: samples on the falling edge, pops and compares.
    bit           prev_req   = 1'b0;
    bit           prev_stall = 1'b0;
    bit           prev_load  = 1'b0;
    logic [31:0]  prev_data  = '0;
    logic [127:0] cur_block  = '0;
    int           req_len    = 0;
    int           ncyc       = 0;
    int           t_start    = 0;

    initial begin
        int lat;
        forever begin
            @(negedge clk);
            ncyc++;
            if (reset_n && !clear) begin
                if (start_i && !busy_o) t_start = ncyc;
                if (pt_ready_o && !prev_load) chk("strb_err_cleared_on_start", strb_err_o, 1'b0);
                if (core_req_o) begin
                    if (!prev_req) begin
                        req_len = 0;
                        if (exp_block_q.size() == 0) flag("unexpected_core_req");
                        else begin
                            cur_block = exp_block_q.pop_front();
                            chk("core_block", core_block_o, cur_block);
                        end
                    end else begin
                        chk("core_block_stable", core_block_o, cur_block);
                    end
                    req_len++;
                    chk("ct_valid_during_req", ct_valid_o, 1'b0);
                end else if (prev_req) begin
                    chk("ct_valid_after_ack", ct_valid_o, 1'b1);
                    if (exp_reqlen_q.size() == 0) flag("unexpected_req_len");
                    else chk("req_len", req_len, exp_reqlen_q.pop_front());
                end
                if (ct_valid_o) begin
                    if (prev_stall) chk("ct_data_stable", ct_data_o, prev_data);
                    chk("ct_strb", ct_strb_o, 4'hF);
                    if (ct_ready_i) begin
                        if (exp_word_q.size() == 0) flag("unexpected_ct_word");
                        else chk("ct_word", ct_data_o, exp_word_q.pop_front());
                    end
                end
                if (done_o) begin
                    done_cnt++;
                    if (exp_err_q.size() == 0) flag("unexpected_done");
                    else begin
                        chk("strb_err_at_done", strb_err_o, exp_err_q.pop_front());
                        lat = exp_lat_q.pop_front();
                        if (lat != 0) chk("latency", ncyc - t_start + 1, lat);
                    end
                end
            end
            prev_req   = core_req_o;
            prev_load  = pt_ready_o;
            prev_stall = ct_valid_o && !ct_ready_i;
            prev_data  = ct_data_o;
        end
    end

    // One full block: builds the expected block/ciphertext from the plaintext, then drives it.
    task automatic run_block(input logic [127:0] k, input int gap_pct, input int dly,
                             input int rmode, input bit spur_start, input bit spur_ack, input int lat);
        logic [127:0] blk, res;
        bit hs, seen, spurred, do_spur, err;
        int guard;
        blk = '0;
        err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ts[i] != 4'hF) err = 1'b1;
            for (int b = 0; b < 4; b++)
                if (ts[i][b]) blk[i*32 + b*8 +: 8] = tw[i][b*8 +: 8];
        end
        res = blk ^ k;
        exp_block_q.push_back(blk);
        for (int i = 0; i < 4; i++) exp_word_q.push_back(res[i*32 +: 32]);
        exp_err_q.push_back(err);
        exp_reqlen_q.push_back(dly + 1);
        exp_lat_q.push_back(lat);
        exp_done++;
        key         = k;
        ack_delay   = dly;
        ready_mode  = rmode;
        spur_ack_en = spur_ack;

        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                pt_valid_i = 1'b0;
                @(posedge clk); #1;
            end
            pt_valid_i = 1'b1;
            pt_data_i  = tw[i];
            pt_strb_i  = ts[i];
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 100) begin
                @(negedge clk);
                hs = pt_ready_o;
                @(posedge clk); #1;
                guard++;
            end
            if (!hs) flag("pt_handshake_timeout");
        end
        pt_valid_i  = 1'b0;
        pt_data_i   = $urandom;
        spur_ack_en = 1'b0;

        seen = 1'b0;
        spurred = 1'b0;
        guard = 0;
        while (!seen && guard < 400) begin
            @(negedge clk);
            seen    = done_o;
            do_spur = spur_start && !spurred && ct_valid_o;
            @(posedge clk); #1;
            start_i = do_spur;
            if (do_spur) spurred = 1'b1;
            guard++;
        end
        start_i = 1'b0;
        if (!seen) flag("done_timeout");
    endtask

    task automatic set_words_random(input bit full_strb);
        for (int i = 0; i < 4; i++) begin
            tw[i] = $urandom;
            ts[i] = full_strb ? 4'hF : (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        clear      = 1'b0;
        start_i    = 1'b0;
        pt_valid_i = 1'b0;
        pt_data_i  = '0;
        pt_strb_i  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_pt_ready", pt_ready_o, 1'b0);
        chk("rst_ct_valid", ct_valid_o, 1'b0);
        chk("rst_core_req", core_req_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_strb_err", strb_err_o, 1'b0);
        chk("rst_word_cnt", word_cnt_o, 2'd0);
        chk("rst_ct_data", ct_data_o, 32'd0);
        chk("rst_core_block", core_block_o, 128'd0);
        chk("rst_ct_strb", ct_strb_o, 4'hF);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic block, XOR-all-ones core, same-cycle ack, 11-cycle latency.
        tw[0] = 32'h03020100; tw[1] = 32'h07060504; tw[2] = 32'h0B0A0908; tw[3] = 32'h0F0E0D0C;
        for (int i = 0; i < 4; i++) ts[i] = 4'hF;
        run_block('1, 0, 0, 0, 1'b0, 1'b0, 11);

        // Backpressure: toggling sink ready, gapped source.
        set_words_random(1'b1);
        run_block({$urandom, $urandom, $urandom, $urandom}, 40, 0, 1, 1'b0, 1'b0, 0);

        // Slow core: ack after 7 cycles of req.
        set_words_random(1'b1);
        run_block({$urandom, $urandom, $urandom, $urandom}, 0, 7, 0, 1'b0, 1'b0, 0);

        // Partial strobe on word 2.
        set_words_random(1'b1);
        tw[2] = 32'hAABBCCDD;
        ts[2] = 4'b0011;
        run_block('1, 0, 0, 0, 1'b0, 1'b0, 0);

        // Next block must start with strb_err cleared.
        set_words_random(1'b1);
        run_block('1, 0, 1, 0, 1'b0, 1'b0, 0);

        // Clear after two words of LOAD.
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pt_valid_i = 1'b1;
            pt_data_i  = $urandom;
            pt_strb_i  = 4'hF;
            @(posedge clk); #1;
        end
        pt_valid_i = 1'b0;
        @(negedge clk);
        chk("cnt_before_clear", word_cnt_o, 2'd2);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear_busy", busy_o, 1'b0);
        chk("clear_pt_ready", pt_ready_o, 1'b0);
        chk("clear_word_cnt", word_cnt_o, 2'd0);
        repeat (5) @(posedge clk);
        #1;
        set_words_random(1'b1);
        run_block({$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 1'b0, 1'b0, 11);

        // Spurious start during DRAIN and spurious ack during LOAD.
        tw[0] = 32'h03020100; tw[1] = 32'h07060504; tw[2] = 32'h0B0A0908; tw[3] = 32'h0F0E0D0C;
        for (int i = 0; i < 4; i++) ts[i] = 4'hF;
        run_block('1, 0, 0, 0, 1'b1, 1'b1, 11);

        // Random mixed traffic.
        for (int n = 0; n < 6; n++) begin
            set_words_random(1'b0);
            run_block({$urandom, $urandom, $urandom, $urandom}, 30, $urandom_range(0, 4), 2,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        repeat (10) @(posedge clk);
        #1;
        chk("done_count", done_cnt, exp_done);
        chk("words_left", exp_word_q.size(), 0);
        chk("blocks_left", exp_block_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_stream_engine.md
Name: aes_stream_engine

Overview:
- Engine-side datapath for the AES HWPE; the receiving/transmitting end of the controller's streamer traffic.
- Accepts plaintext 32-bit words from the HWPE plaintext source stream and assembles one 128-bit block.
- Hands the block to the AES cipher core through a req/ack handshake, then serialises the 128-bit ciphertext into 32-bit words on the ciphertext sink stream.
- Reports busy/done/error flags back to the controller FSM.

Parameters:
- DATA_WIDTH, 32, stream word width in bits.
- BLOCK_WIDTH, 128, cipher block width in bits.
- NB_WORDS, BLOCK_WIDTH/DATA_WIDTH (4), words per block; derived, not overridden.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear; same effect as reset.
- start_i  input  1  single-cycle start pulse from the controller.
- pt_valid_i  input  1  plaintext stream valid.
- pt_ready_o  output  1  plaintext stream ready.
- pt_data_i  input  DATA_WIDTH  plaintext word.
- pt_strb_i  input  DATA_WIDTH/8  plaintext byte strobes.
- ct_valid_o  output  1  ciphertext stream valid.
- ct_ready_i  input  1  ciphertext stream ready.
- ct_data_o  output  DATA_WIDTH  ciphertext word.
- ct_strb_o  output  DATA_WIDTH/8  ciphertext byte strobes.
- core_req_o  output  1  request to the cipher core.
- core_block_o  output  BLOCK_WIDTH  assembled plaintext block.
- core_ack_i  input  1  cipher core acknowledge; result valid in the same cycle.
- core_result_i  input  BLOCK_WIDTH  ciphertext block.
- busy_o  output  1  high in any state other than IDLE.
- done_o  output  1  one-cycle pulse on completion.
- strb_err_o  output  1  sticky partial-strobe error.
- word_cnt_o  output  $clog2(NB_WORDS)  current word index.

Behaviour:
- Clocking and reset: single clock domain. On reset_n low (async) or clear high (sync):
  - state = IDLE.
  - Word counter, block register, result register and strb_err_o = 0.
  - All valid/req/done outputs = 0.
  - ct_data_o = 0.
- States: IDLE, LOAD, CIPHER, DRAIN, DONE.
- IDLE:
  - pt_ready_o = 0, ct_valid_o = 0.
  - start_i = 1 -> LOAD; word counter and strb_err_o cleared on the same edge.
- LOAD:
  - pt_ready_o = 1.
  - On each pt_valid_i && pt_ready_o, store pt_data_i into block bits [cnt*32 +: 32]. The first word goes to [31:0] (little-endian word order).
  - Bytes whose strobe bit is 0 are stored as 0x00. If any strobe bit is 0, strb_err_o is set and stays set until the next start.
  - Counter increments per accepted word. The handshake on word NB_WORDS-1 -> CIPHER, counter wraps to 0, and pt_ready_o drops the next cycle.
  - Idle cycles (pt_valid_i = 0) are permitted indefinitely.
- CIPHER:
  - core_req_o = 1; core_block_o = block register, stable throughout.
  - On core_ack_i = 1: latch core_result_i, then -> DRAIN.
  - An ack in the first CIPHER cycle is legal (minimum one cycle in CIPHER). core_ack_i outside CIPHER is ignored.
- DRAIN:
  - ct_valid_o = 1; ct_data_o = result[cnt*32 +: 32]; ct_strb_o = all ones.
  - ct_data_o is held stable while ct_valid_o && !ct_ready_i. ct_valid_o never drops before a handshake, except on clear or reset.
  - The counter increments on each handshake. The handshake on the last word -> DONE.
- DONE:
  - done_o = 1 for exactly one cycle, then -> IDLE.
- start_i outside IDLE is ignored.
- Outputs held constant in states where they are not driven:
  - core_block_o = block register (all states).
  - ct_strb_o = all ones.
  - word_cnt_o = counter.
- Latency: with always-valid and always-ready streams and a same-cycle ack, start to done_o = 1 (IDLE->LOAD) + 4 (LOAD) + 1 (CIPHER) + 4 (DRAIN) + 1 (DONE) = 11 cycles.
- Clear mid-operation: an immediate return to IDLE; partial block data is discarded, and no done_o is produced.
- Simultaneous clear and start_i: clear wins.

Test Plan:
- Basic block: start, then plaintext 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with the stream always valid, and a core that acks in the first cycle with result = block XOR 0xFF..FF. Required: core_block_o = 0x0F0E0D0C_0B0A0908_07060504_03020100; ct words 0xFCFDFEFF, 0xF8F9FAFB, 0xF4F5F6F7, 0xF0F1F2F3; done_o at cycle 11; strb_err_o = 0.
- Backpressure: ct_ready_i toggled 1010... and pt_valid_i randomly gapped. Required: every word transferred exactly once, in order; ct_data_o stable during stalls; done_o exactly once.
- Slow core: core_ack_i delayed 7 cycles. Required: core_req_o high for 8 cycles; core_block_o constant; ct_valid_o stays 0 until the cycle after the ack.
- Partial strobe: word 2 sent with strb = 4'b0011, data 0xAABBCCDD. Required: block bits [95:64] = 0x0000CCDD; strb_err_o = 1 through DONE; strb_err_o cleared by the next start_i.
- Clear mid-LOAD: clear asserted after 2 words. Required: next cycle busy_o = 0, pt_ready_o = 0, word_cnt_o = 0; no done_o. A following full block completes normally.
- Spurious inputs: start_i pulsed during DRAIN and core_ack_i pulsed during LOAD. Required: both ignored; state sequence and output words unchanged.
